// File: rtl/ibus_xfer_master_if.sv
// IBUS initiator/target signal bundle: the master drives address, data, enables and request,
// and the slave answers with read data and a wait (busy) indication.
interface ibus_xfer_master_if;
  logic [31:0] IBUS_A;
  logic [31:0] IBUS_DO;
  logic [31:0] IBUS_DI;
  logic [3:0]  IBUS_BA;
  logic        IBUS_WE;
  logic        IBUS_REQ;
  logic        IBUS_BUSY;

  modport master (
    output IBUS_A, IBUS_DO, IBUS_BA, IBUS_WE, IBUS_REQ,
    input  IBUS_DI, IBUS_BUSY
  );

  modport slave (
    input  IBUS_A, IBUS_DO, IBUS_BA, IBUS_WE, IBUS_REQ,
    output IBUS_DI, IBUS_BUSY
  );
endinterface

// File: rtl/ibus_xfer_master.sv
// IBUS block copier: one read then one write phase per longword; IRQ/vector latch built only with `IBUS_XFER_IRQ_EN.
// Start->REQ 1 CE_R cycle, 2 cycles/element plus 1 per IBUS_BUSY cycle; registered bus outputs hold while busy.
module ibus_xfer_master #(
  parameter logic [7:0] VEC_RESET = 8'h00
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CE_R,
  input  logic        CE_F,
  input  logic [31:0] CMD_SRC,
  input  logic [31:0] CMD_DST,
  input  logic [15:0] CMD_CNT,
  input  logic        CMD_SINC,
  input  logic        CMD_DINC,
  input  logic [7:0]  CMD_VEC,
  input  logic        CMD_START,
  input  logic        CMD_ABORT,
  ibus_xfer_master_if.master ibus,
  output logic        ACTIVE,
  output logic        DONE,
  output logic        ABORTED,
  output logic [15:0] REMAIN,
  output logic        IRQ,
  output logic [7:0]  VEC
);

  typedef enum logic [1:0] {ST_IDLE, ST_RD, ST_WR, ST_FIN} state_t;

  state_t      state_q, state_d;
  logic [31:0] src_q, src_d, dst_q, dst_d, a_q, a_d, do_q, do_d;
  logic [15:0] rem_q, rem_d;
  logic        sinc_q, sinc_d, dinc_q, dinc_d, abort_q, abort_d;
  logic        done_q, done_d, aborted_q, aborted_d, req_q, req_d, we_q, we_d;
  logic        start_ok, abort_pend;
  logic        ce_f_unused;

  assign ce_f_unused = CE_F;

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    dst_d      = dst_q;
    rem_d      = rem_q;
    sinc_d     = sinc_q;
    dinc_d     = dinc_q;
    abort_d    = abort_q;
    done_d     = done_q;
    aborted_d  = aborted_q;
    a_d        = a_q;
    do_d       = do_q;
    start_ok   = 1'b0;
    abort_pend = abort_q | CMD_ABORT;
    if (CE_R) begin
      case (state_q)
        ST_IDLE: begin
          if (CMD_START) begin
            start_ok  = 1'b1;
            src_d     = CMD_SRC;
            dst_d     = CMD_DST;
            rem_d     = CMD_CNT;
            sinc_d    = CMD_SINC;
            dinc_d    = CMD_DINC;
            done_d    = 1'b0;
            aborted_d = 1'b0;
            abort_d   = 1'b0;
            state_d   = (CMD_CNT == 16'd0) ? ST_FIN : ST_RD;
          end
        end
        ST_RD: begin
          abort_d = abort_pend;
          if (!ibus.IBUS_BUSY) begin
            if (sinc_q) src_d = src_q + 32'd4;
            // A pending abort drops the just-read word instead of writing it.
            if (abort_pend) begin
              state_d = ST_FIN;
            end else begin
              do_d    = ibus.IBUS_DI;
              state_d = ST_WR;
            end
          end
        end
        ST_WR: begin
          abort_d = abort_pend;
          if (!ibus.IBUS_BUSY) begin
            rem_d = rem_q - 16'd1;
            if (dinc_q) dst_d = dst_q + 32'd4;
            state_d = ((rem_q == 16'd1) || abort_pend) ? ST_FIN : ST_RD;
          end
        end
        default: begin
          done_d    = 1'b1;
          aborted_d = abort_q;
          abort_d   = 1'b0;
          state_d   = ST_IDLE;
        end
      endcase
    end
    // Bus outputs are registered from the state being entered so they are valid on its first cycle.
    req_d = (state_d == ST_RD) || (state_d == ST_WR);
    we_d  = (state_d == ST_WR);
    if (state_d == ST_RD)      a_d = {src_d[31:2], 2'b00};
    else if (state_d == ST_WR) a_d = {dst_d[31:2], 2'b00};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      rem_q     <= '0;
      sinc_q    <= 1'b0;
      dinc_q    <= 1'b0;
      abort_q   <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      a_q       <= '0;
      do_q      <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      rem_q     <= rem_d;
      sinc_q    <= sinc_d;
      dinc_q    <= dinc_d;
      abort_q   <= abort_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      a_q       <= a_d;
      do_q      <= do_d;
      req_q     <= req_d;
      we_q      <= we_d;
    end
  end

  assign ibus.IBUS_A   = a_q;
  assign ibus.IBUS_DO  = do_q;
  assign ibus.IBUS_WE  = we_q;
  assign ibus.IBUS_REQ = req_q;
  assign ibus.IBUS_BA  = {4{req_q}};
  assign ACTIVE        = (state_q != ST_IDLE);
  assign DONE          = done_q;
  assign ABORTED       = aborted_q;
  assign REMAIN        = rem_q;

`ifdef IBUS_XFER_IRQ_EN
  logic [7:0] vec_q, vec_d;
  logic       irq_en_q, irq_en_d;

  always_comb begin
    vec_d    = vec_q;
    irq_en_d = irq_en_q;
    if (start_ok) begin
      vec_d    = CMD_VEC;
      irq_en_d = (CMD_VEC != 8'h00);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      vec_q    <= VEC_RESET;
      irq_en_q <= 1'b0;
    end else begin
      vec_q    <= vec_d;
      irq_en_q <= irq_en_d;
    end
  end

  assign IRQ = done_q & irq_en_q;
  assign VEC = vec_q;
`else
  logic cmd_vec_unused;
  assign cmd_vec_unused = ^{CMD_VEC, start_ok};
  assign IRQ = 1'b0;
  assign VEC = VEC_RESET;
`endif

endmodule

// File: doc/ibus_xfer_master.md
# ibus_xfer_master

Single-channel IBUS initiator that moves a block of 32-bit longwords from a source address to a destination address, one read phase then one write phase per element. It sits on the internal bus beside the CPU core and drives the same IBUS signals that on-chip peripherals such as the divider respond to. The block can therefore load operand registers, read results back, or copy memory without CPU intervention.

## Interface
Parameters:
- `VEC_RESET`, 8'h00: reset value of the interrupt vector register.

Ports:
- `CLK`  in  1  system clock.
- `RST`  in  1  synchronous, active-high reset. Sampled on posedge `CLK`, independent of `CE_R`.
- `CE_R`  in  1  rising-phase clock enable. All state advances only when `CE_R`=1.
- `CE_F`  in  1  falling-phase enable. Unused internally; present for port uniformity.
- `CMD_SRC`  in  32  source start address, longword aligned.
- `CMD_DST`  in  32  destination start address, longword aligned.
- `CMD_CNT`  in  16  longword count.
- `CMD_SINC`  in  1  1: source address +4 per element; 0: fixed.
- `CMD_DINC`  in  1  1: destination address +4 per element; 0: fixed.
- `CMD_VEC`  in  8  interrupt vector, latched at start.
- `CMD_START`  in  1  start pulse. Honoured only in IDLE.
- `CMD_ABORT`  in  1  abort request pulse.
- `IBUS_A`  out  32  bus address.
- `IBUS_DO`  out  32  write data.
- `IBUS_DI`  in  32  read data.
- `IBUS_BA`  out  4  byte enables. Always 4'hF while `IBUS_REQ`=1, else 0.
- `IBUS_WE`  out  1  1 = write phase.
- `IBUS_REQ`  out  1  bus request.
- `IBUS_BUSY`  in  1  slave wait. The phase completes on the first `CE_R` cycle with `IBUS_BUSY`=0.
- `ACTIVE`  out  1  transfer in progress.
- `DONE`  out  1  sticky completion flag. Cleared by the next `CMD_START`.
- `ABORTED`  out  1  sticky. Set when a transfer ended by abort.
- `REMAIN`  out  16  elements not yet written.
- `IRQ`  out  1  completion interrupt. See Configuration.
- `VEC`  out  8  latched vector.

## Operation
- States: IDLE, RD, WR, FIN.
- IDLE + `CMD_START`:
  - latch SRC, DST, CNT, SINC, DINC and VEC;
  - clear `DONE` and `ABORTED`;
  - if CNT=0, go to FIN; else go to RD.
- RD:
  - drive `IBUS_REQ`=1, `IBUS_WE`=0, `IBUS_A`=src.
  - On completion, capture `IBUS_DI` into the data latch and go to WR.
  - If SINC=1, src += 4 (wraps modulo 2^32).
- WR:
  - drive `IBUS_REQ`=1, `IBUS_WE`=1, `IBUS_A`=dst, `IBUS_DO`=data latch.
  - On completion, REMAIN -= 1 and, if DINC=1, dst += 4.
  - Next state is FIN if REMAIN reaches 0 or an abort is pending; else RD.
- FIN: set `DONE`=1 and go to IDLE. `ACTIVE`=1 in RD, WR and FIN.
- Abort handling:
  - `CMD_ABORT` sets a pending flag. An active phase is never dropped: the current RD or WR completes first.
  - Abort pending at RD completion: the data is discarded and the FSM goes to FIN without a write.
  - FIN with abort pending: `ABORTED`=1 and `DONE`=1.
  - `CMD_ABORT` in IDLE is ignored.
  - `CMD_START` during an active transfer is ignored.
- Simultaneous `CMD_START` and `CMD_ABORT` in IDLE: the start wins and the abort is ignored.
- Address bits [1:0] are forced to 0 on `IBUS_A`.

## Timing
- Reset values:
  - `IBUS_REQ`, `IBUS_WE`, `ACTIVE`, `DONE`, `ABORTED`, `IRQ` = 0;
  - `IBUS_A`, `IBUS_DO` = 0; `IBUS_BA`=0; `REMAIN`=0;
  - `VEC`=`VEC_RESET`; state IDLE.
- `RST` mid-transfer: immediate return to IDLE with all reset values, including dropping `IBUS_REQ`.
- Latency from `CMD_START` to `IBUS_REQ` asserted: 1 `CE_R` cycle.
- With zero wait, each element takes 2 `CE_R` cycles. Each `IBUS_BUSY` cycle adds 1.
- Bus outputs are registered and remain stable while `IBUS_BUSY`=1.
- In the `CE_R` cycle where the last write completes, the next cycle is FIN. `DONE` rises one cycle after FIN.
- Total for N elements with zero wait: 2N+2 `CE_R` cycles from start to `DONE`.
- CNT=0: `DONE` is set 2 cycles after start, with no bus activity.
- Cycles with `CE_R`=0 hold all state.

## Configuration
- `IBUS_XFER_IRQ_EN` defined:
  - `IRQ` = `DONE` & interrupt-enabled-at-start, where the enable is the registered value of `CMD_VEC`≠0.
  - `IRQ` clears when `DONE` clears.
- `IBUS_XFER_IRQ_EN` undefined:
  - `IRQ` tied to 0;
  - `VEC` tied to `VEC_RESET`; no vector latch is synthesized.

## Test plan
- SRC=0x1000, DST=0xFFFFFF00, CNT=2, SINC=DINC=1, memory {0x0000000A, 0x00000064}, zero wait:
  - writes 0xA to FF00 and 0x64 to FF04;
  - `DONE` at cycle 6; `REMAIN`=0.
- CNT=3, DINC=0, DST=0xFFFFFF04, `IBUS_BUSY` held 3 cycles on the second read:
  - three writes to FF04;
  - `IBUS_A` stable during the wait;
  - total 11 cycles.
- CNT=0 start:
  - no `IBUS_REQ`;
  - `DONE`=1 after 2 cycles; `ABORTED`=0.
- CNT=4, `CMD_ABORT` during the second RD with `IBUS_BUSY`=1:
  - the read completes and no second write occurs;
  - `ABORTED`=1, `DONE`=1, `REMAIN`=3.
- `RST` asserted during WR:
  - `IBUS_REQ`=0 next cycle; all outputs at reset values;
  - a subsequent start with CNT=1 runs normally.
- With `IBUS_XFER_IRQ_EN`, CMD_VEC=0x48, CNT=1:
  - `IRQ`=1 and `VEC`=0x48 after completion;
  - the next `CMD_START` clears `IRQ`.
  - Without the macro, `IRQ` stays 0.
